// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte (for example 0xED
// set-LEDs or 0xFF reset) to a keyboard. The sequence is:
//   1. Inhibit: ps2_clk is held low for INHIBIT_CYCLES system clocks.
//   2. Request-to-send: ps2_data is pulled low (start bit), then ps2_clk is
//      released so the device can begin clocking.
//   3. On every device clock falling edge the next bit goes out, LSB first:
//      d0..d7, odd parity, stop.
//   4. On the 11th falling edge the device's line-ack is sampled.
//   5. The transmitter waits for both lines to return high, then signals done.
// A timeout counter covers the whole device-clocked part of the transfer.
//
// Ports:
//   clk          system clock; all logic on posedge
//   rst          synchronous, active-high reset
//   tx_start     1-cycle request, accepted only while busy=0
//   tx_data      command byte, captured when tx_start is accepted
//   ps2_clk_in   raw PS/2 clock pin level (asynchronous)
//   ps2_data_in  raw PS/2 data pin level (asynchronous)
//   ps2_clk_oe   1 = pull ps2_clk low, 0 = release (registered)
//   ps2_data_oe  1 = pull ps2_data low, 0 = release (registered)
//   busy         high from the cycle after accept until the done cycle
//   done         1-cycle pulse at the end of a transfer (success or failure)
//   ack_err      valid with done, held until the next accept;
//                1 = device did not ack, or the transfer timed out
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    // One counter serves both the inhibit interval and the timeout, since
    // the two phases never overlap.
    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT     = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [3:0]        bit_cnt;
    logic [3:0]        bit_cnt_n;
    logic [10:0]       shreg;
    logic [10:0]       shreg_n;
    logic              ack_err_n;
    logic              clk_oe_n;
    logic              data_oe_n;

    logic              clk_meta;
    logic              clk_sync;
    logic              clk_hist;
    logic              data_meta;
    logic              data_sync;
    logic              fe;
    logic              timeout;

    // Pin synchronizers: two flops for metastability, one extra history flop
    // on the clock so a falling edge can be detected on synchronized levels.
    always_ff @(posedge clk) begin
        clk_meta  <= ps2_clk_in;
        clk_sync  <= clk_meta;
        clk_hist  <= clk_sync;
        data_meta <= ps2_data_in;
        data_sync <= data_meta;
    end

    assign fe      = clk_hist & ~clk_sync;
    assign timeout = (cnt == TIMEOUT_LAST);

    // Next-state and datapath logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        ack_err_n = ack_err;

        case (state)
            S_IDLE: begin
                if (tx_start) begin
                    state_n   = S_INHIBIT;
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    // Bit 0 is the start bit so that the line value is
                    // always shreg[0]; ones shift in behind the stop bit.
                    shreg_n   = {1'b1, ~^tx_data, tx_data, 1'b0};
                    ack_err_n = 1'b0;
                end
            end

            S_INHIBIT: begin
                if (cnt == INHIBIT_LAST) begin
                    state_n = S_REQ;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_REQ: begin
                state_n = S_SEND;
                cnt_n   = '0;
            end

            S_SEND: begin
                // A timeout wins over a clock edge arriving in the same cycle.
                if (timeout) begin
                    state_n   = S_DONE;
                    ack_err_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (fe) begin
                        if (bit_cnt == LAST_BIT) begin
                            // 11th falling edge: the device drives its ack now.
                            state_n   = S_ACK;
                            ack_err_n = data_sync;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                            shreg_n   = {1'b1, shreg[10:1]};
                        end
                    end
                end
            end

            S_ACK: begin
                if (timeout) begin
                    state_n   = S_DONE;
                    ack_err_n = 1'b1;
                end else begin
                    cnt_n   = cnt + 1'b1;
                    state_n = S_WAIT_IDLE;
                end
            end

            S_WAIT_IDLE: begin
                if (timeout) begin
                    state_n   = S_DONE;
                    ack_err_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (clk_sync && data_sync) begin
                        state_n = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Line drivers are decoded from the next state and registered so the
    // open-drain enables never glitch.
    always_comb begin
        clk_oe_n  = (state_n == S_INHIBIT) || (state_n == S_REQ);
        data_oe_n = (state_n == S_REQ) || ((state_n == S_SEND) && !shreg_n[0]);
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            ack_err     <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_cnt     <= bit_cnt_n;
            ack_err     <= ack_err_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            busy        <= (state_n != S_IDLE);
            done        <= (state_n == S_DONE);
        end
    end

    // Frame shift register
    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Bench for ps2_host_tx. A behavioural PS/2 device drives the shared
// open-drain lines, records the 11 bits it clocks in and optionally acks.
// Expected results are queued when a transfer is started and checked by a
// monitor when the done pulse appears.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TMO  = 2000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;

    logic       dev_clk_lo  = 1'b0;
    logic       dev_data_lo = 1'b0;

    // Wired-AND of host and device open-drain drivers with pull-ups.
    assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_lo);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_lo);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          chk_frame;
        logic [10:0] frame;
        logic        ack_err;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        bit         dev_ack;
        logic       par;
        logic       err;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[5];
    logic [10:0] dev_frame;
    int          done_cnt = 0;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d, input logic par);
        return {1'b1, par, d, 1'b0};
    endfunction

    // Scoreboard monitor: every done pulse consumes one expected record.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no transfer pending");
                end else begin
                    e = sb.pop_front();
                    check1("ack_err", ack_err, e.ack_err);
                    if (e.chk_frame) check1("frame", dev_frame, e.frame);
                end
            end
        end
    end

    // Device model: waits for request-to-send, then generates nclk clocks,
    // sampling the data line just before each falling edge.
    task automatic device_xfer(input bit do_ack, input int nclk);
        int n;
        n = 0;
        dev_frame = '0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 800);
        check1("rts_seen", (ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1), 1);
        if (ps2_data_oe !== 1'b1) return;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < nclk; k++) begin
            dev_frame[k] = ps2_data_in;
            if (k == 10 && do_ack) begin
                dev_data_lo = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_lo = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_lo = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data_lo = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < limit);
        check1("done_seen", done, 1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        check1("busy_after_accept", busy, 1);
        check1("clk_oe_inhibit", ps2_clk_oe, 1);
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin : main
        int d0;
        int c0;
        int c1;
        int n;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0};

        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (4) @(negedge clk);
        check1("rst_clk_oe", ps2_clk_oe, 0);
        check1("rst_data_oe", ps2_data_oe, 0);
        check1("rst_busy", busy, 0);
        check1("rst_done", done, 0);
        check1("rst_ack_err", ack_err, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven transfers
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{1'b1, frame_of(vecs[i].data, vecs[i].par), vecs[i].err});
            send_byte(vecs[i].data);
            fork
                device_xfer(vecs[i].dev_ack, 11);
                wait_done(3000);
            join
            repeat (5) @(negedge clk);
        end

        // Start request while busy is ignored
        d0 = done_cnt;
        sb.push_back('{1'b1, frame_of(8'hF4, 1'b0), 1'b0});
        send_byte(8'hF4);
        fork
            device_xfer(1'b1, 11);
            begin
                repeat (10) @(negedge clk);
                tx_start = 1'b1;
                tx_data  = 8'h55;
                @(negedge clk);
                tx_start = 1'b0;
            end
            wait_done(3000);
        join
        repeat (300) @(negedge clk);
        check1("single_done", done_cnt, d0 + 1);

        // Reset in the middle of a transfer, after the 4th device clock
        d0 = done_cnt;
        send_byte(8'h00);
        device_xfer(1'b0, 4);
        check1("data_oe_before_rst", ps2_data_oe, 1);
        check1("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check1("midrst_clk_oe", ps2_clk_oe, 0);
        check1("midrst_data_oe", ps2_data_oe, 0);
        check1("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        sb.push_back('{1'b1, frame_of(8'h5A, 1'b1), 1'b0});
        send_byte(8'h5A);
        fork
            device_xfer(1'b1, 11);
            wait_done(3000);
        join
        check1("done_after_rst", done_cnt, d0 + 1);
        repeat (5) @(negedge clk);

        // Device never clocks: timeout exactly TMO cycles after SEND entry
        sb.push_back('{1'b0, 11'h000, 1'b1});
        send_byte(8'h3C);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps2_clk_oe !== 1'b0 && n < 200);
        c0 = cyc;
        check1("start_bit_held", ps2_data_oe, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < TMO + 500);
        c1 = cyc;
        check1("timeout_done", done, 1);
        check1("timeout_cycles", c1 - c0, TMO);
        check1("timeout_clk_oe", ps2_clk_oe, 0);
        check1("timeout_data_oe", ps2_data_oe, 0);
        repeat (5) @(negedge clk);
        check1("idle_busy", busy, 0);
        check1("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
